mux41_rr_arb: RTL

Round-robin arbiter and sequencer that shares one 4-way, 2-bit key mux (keys 2'b00..2'b11, default 2'b11) among four requesters. It selects a requester, drives the mux select, registers the selected 2-bit slice and presents it downstream on a valid/ready handshake. It sits between the four producer lanes and the single shared consumer of the mux output.

---
 rtl/mux41_pkg.sv | 36 +++
 rtl/mux41_rr_pick.sv | 34 +++
 rtl/mux41_rr_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/mux41_pkg.sv
// ============================================================================
// mux41_pkg : shared types, constants and key mux for the mux41 arbiter
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package mux41_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NR_REQ   = 4;
  localparam int DATA_LEN = 2;
  localparam int SEL_W    = 2;

  localparam logic [DATA_LEN-1:0] DEFAULT_OUT = 2'b11;

  // 4-way key mux; every 2-bit key is listed, so the default arm is never taken
  function automatic logic [DATA_LEN-1:0] key_mux(
    input logic [SEL_W-1:0]           key,
    input logic [NR_REQ*DATA_LEN-1:0] data
  );
    case (key)
      2'b00:   key_mux = data[1:0];
      2'b01:   key_mux = data[3:2];
      2'b10:   key_mux = data[5:4];
      2'b11:   key_mux = data[7:6];
      default: key_mux = DEFAULT_OUT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux41_rr_pick.sv
// ============================================================================
// mux41_rr_pick : combinational round-robin winner search starting at ptr
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module mux41_rr_pick
  import mux41_pkg::*;
(
  input  logic [NR_REQ-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  winner,
  output logic              any_req
);

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the lane closest to ptr wins
  always_comb begin
    winner = ptr;
    w_idx  = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      w_idx = ptr + SEL_W'(k);
      if (req[w_idx]) begin
        winner = w_idx;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/mux41_rr_arb.sv
// ============================================================================
// mux41_rr_arb : round-robin sequencer for a shared 4-way 2-bit key mux with
//                valid/ready output. Optional grant counters: MUX41_RR_ARB_CNT_EN
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module mux41_rr_arb
  import mux41_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          req,
  input  logic [NR_REQ*DATA_LEN-1:0] a,
  output logic [NR_REQ-1:0]          gnt,
  output logic [DATA_LEN-1:0]        y,
  output logic [SEL_W-1:0]           y_src,
  output logic                       y_valid,
  input  logic                       y_ready
`ifdef MUX41_RR_ARB_CNT_EN
  ,
  output logic [NR_REQ*CNT_W-1:0]    cnt_o
`endif
);

  state_t               state_q, state_d;
  logic [DATA_LEN-1:0]  y_q, y_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;

  logic [SEL_W-1:0]     w_winner;
  logic                 w_any_req;
  logic [SEL_W-1:0]     w_sel;
  logic [DATA_LEN-1:0]  w_mux_out;
  logic                 w_capture;

  mux41_rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_sel     = w_winner;
  assign w_mux_out = key_mux(w_sel, a);

  // Gated by rst_n so no grant is ever issued while reset is asserted
  assign w_capture = rst_n && w_any_req && ((state_q == IDLE) || y_ready);
  assign gnt       = w_capture ? (NR_REQ'(1) << w_winner) : '0;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (w_capture) begin
      state_d = BUSY;
      y_d     = w_mux_out;
      src_d   = w_winner;
      ptr_d   = w_winner + SEL_W'(1);
    end else if ((state_q == BUSY) && y_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_src   = src_q;
  assign y_valid = (state_q == BUSY);

`ifdef MUX41_RR_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [NR_REQ];

  for (genvar i = 0; i < NR_REQ; i++) begin : g_cnt
    // Saturating: stops at all-ones instead of wrapping
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign cnt_o[CNT_W*i +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

`default_nettype wire
